// File: rtl/non_blocking_pkg.sv
// Shared types and the wrap/saturate adder for non_blocking_demo.
// Define NB_SAT_EN to make the sum saturate instead of wrapping.
package non_blocking_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 3;
  localparam int MAX_W     = 32;

  typedef logic [DEF_WIDTH-1:0] data_t;

  // Width-generic add; caller truncates the result to w bits (w <= MAX_W).
  function automatic logic [MAX_W-1:0] add_f(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input int unsigned      w);
    logic [MAX_W:0] s;
    logic [MAX_W:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
`ifdef NB_SAT_EN
    if (s > m) s = m;
`endif
    return MAX_W'(s & m);
  endfunction
endpackage

// File: rtl/non_blocking_demo_stage.sv
// One WIDTH-bit pipeline register with synchronous active-high reset and enable.
module nb_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rstn)    q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/non_blocking_demo.sv
// A+B through a DEPTH-stage register chain and through a collapsed single-register chain.
// Define NB_SAT_EN to saturate the sum instead of wrapping.
module non_blocking_demo
  import non_blocking_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ena,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] dout_non_blocking,
  output logic [WIDTH-1:0] dout_blocking
);
  logic [WIDTH-1:0]            sum;
  logic [DEPTH-1:0][WIDTH-1:0] s;
  logic [DEPTH-1:0][WIDTH-1:0] t;

  assign sum = WIDTH'(add_f(MAX_W'(A), MAX_W'(B), WIDTH));

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      nb_stage #(.WIDTH(WIDTH)) u_stage (
        .clk(clk), .rstn(rstn), .en(ena), .d(sum), .q(s[g])
      );
    end else begin : g_body
      nb_stage #(.WIDTH(WIDTH)) u_stage (
        .clk(clk), .rstn(rstn), .en(ena), .d(s[g-1]), .q(s[g])
      );
    end
  end

  assign dout_non_blocking = s[DEPTH-1];

  // In-order evaluation passes sum straight through t[], so only the
  // final output is actually registered.
  always_comb begin
    t    = '0;
    t[0] = sum;
    for (int i = 1; i < DEPTH; i++) t[i] = t[i-1];
  end

  always_ff @(posedge clk) begin
    if (rstn)     dout_blocking <= '0;
    else if (ena) dout_blocking <= t[DEPTH-1];
  end
endmodule

// File: tb/tb_non_blocking_demo.sv
// Directed bench for non_blocking_demo (WIDTH=8, DEPTH=3); honours NB_SAT_EN.
module tb_non_blocking_demo;
  logic       clk = 1'b0;
  logic       rstn, ena;
  logic [7:0] A, B;
  logic [7:0] dout_non_blocking, dout_blocking;
  int         nvec = 0;
  int         nerr = 0;

  non_blocking_demo #(.WIDTH(8), .DEPTH(3)) dut (
    .clk(clk), .rstn(rstn), .ena(ena), .A(A), .B(B),
    .dout_non_blocking(dout_non_blocking), .dout_blocking(dout_blocking)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [7:0] enb, input logic [7:0] eb);
    chk({tag, "/nb"}, dout_non_blocking, enb);
    chk({tag, "/blk"}, dout_blocking, eb);
  endtask

  initial begin
    logic [7:0] ovf_exp, max_exp;
`ifdef NB_SAT_EN
    ovf_exp = 8'd255;
    max_exp = 8'd255;
`else
    ovf_exp = 8'd44;
    max_exp = 8'd254;
`endif
    rstn = 1'b1; ena = 1'b1; A = 8'd9; B = 8'd9;

    // 1: reset (overrides ena), then hold with ena low
    tick(); tick();
    chk2("reset", 8'd0, 8'd0);
    rstn = 1'b0; ena = 1'b0; A = 8'd5; B = 8'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk2("idle", 8'd0, 8'd0);
    end

    // 2: first enabled edges
    ena = 1'b1;
    tick(); chk2("fill1", 8'd0, 8'd12);
    tick(); chk2("fill2", 8'd0, 8'd12);
    tick(); chk2("fill3", 8'd12, 8'd12);

    // 3: back-to-back operands
    A = 8'd1; B = 8'd1; tick(); chk2("bb1", 8'd12, 8'd2);
    A = 8'd2; B = 8'd2; tick(); chk2("bb2", 8'd12, 8'd4);
    A = 8'd3; B = 8'd3; tick(); chk2("bb3", 8'd2,  8'd6);
    A = 8'd4; B = 8'd4; tick(); chk2("bb4", 8'd4,  8'd8);
    A = 8'd5; B = 8'd5; tick(); chk2("bb5", 8'd6,  8'd10);

    // 4: stall with operand change, then drain in order
    ena = 1'b0; A = 8'd50; B = 8'd50;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk2("stall", 8'd6, 8'd10);
    end
    ena = 1'b1;
    tick(); chk2("resume1", 8'd8,   8'd100);
    tick(); chk2("resume2", 8'd10,  8'd100);
    tick(); chk2("resume3", 8'd100, 8'd100);

    // 5: mid-stream reset flush and refill
    A = 8'd1; B = 8'd2;
    tick(); chk2("pre_rst", 8'd100, 8'd3);
    rstn = 1'b1;
    tick(); chk2("flush", 8'd0, 8'd0);
    rstn = 1'b0;
    tick(); chk2("refill1", 8'd0, 8'd3);
    tick(); chk2("refill2", 8'd0, 8'd3);
    tick(); chk2("refill3", 8'd3, 8'd3);

    // 6: overflow boundaries
    A = 8'd200; B = 8'd100;
    tick(); chk2("ovf1", 8'd3, ovf_exp);
    A = 8'd255; B = 8'd255;
    tick(); chk2("max1", 8'd3, max_exp);
    A = 8'd0; B = 8'd0;
    tick(); chk2("ovf3", ovf_exp, 8'd0);
    tick(); chk2("max3", max_exp, 8'd0);
    tick(); chk2("zero3", 8'd0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
